// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) line-burst arbiter onto one shared memory word port.
// Contention alternates between clients; every grant runs a full LINE_WORDS burst then one DONE cycle.
module mem_arbiter #(
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_req,
  input  logic [31:0]                   i_addr,
  output logic                          i_rvalid,
  output logic [31:0]                   i_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] i_widx,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [31:0]                   d_addr,
  input  logic [31:0]                   d_wdata,
  output logic                          d_rvalid,
  output logic [31:0]                   d_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] d_widx,
  output logic                          d_done,
  output logic                          d_wack,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_ready
);
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int BASE_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, I_BURST, D_BURST, DONE} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [BASE_W-1:0]   base_reg;
  logic                we_reg;
  logic                owner_d_reg;
  logic                last_d_reg;
  logic                grant_d;
  logic                in_i;
  logic                in_d;
  logic                in_burst;
  logic                unused_addr_bits;

  // Word offset bits of the request addresses are regenerated from idx_reg.
  assign unused_addr_bits = ^{i_addr[IDX_W+1:0], d_addr[IDX_W+1:0]};

  // D wins when alone, or on a tie when I was granted last.
  assign grant_d = d_req && (!i_req || !last_d_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      base_reg    <= '0;
      we_reg      <= 1'b0;
      owner_d_reg <= 1'b0;
      last_d_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d_reg <= grant_d;
            last_d_reg  <= grant_d;
            we_reg      <= grant_d && d_we;
            base_reg    <= grant_d ? d_addr[31:IDX_W+2] : i_addr[31:IDX_W+2];
            idx_reg     <= '0;
            state_reg   <= grant_d ? D_BURST : I_BURST;
          end
        end
        I_BURST, D_BURST: begin
          if (mem_ready) begin
            // Wraps to 0 on the last word, leaving idx cleared for DONE.
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg == IDX_W'(LINE_WORDS - 1)) begin
              state_reg <= DONE;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_i     = (state_reg == I_BURST);
  assign in_d     = (state_reg == D_BURST);
  assign in_burst = in_i || in_d;

  assign mem_req   = in_burst;
  assign mem_we    = in_burst && we_reg;
  assign mem_addr  = in_burst ? {base_reg, idx_reg, 2'b00} : 32'd0;
  assign mem_wdata = in_burst ? d_wdata : 32'd0;

  assign i_rvalid = in_i && mem_ready;
  assign i_rdata  = i_rvalid ? mem_rdata : 32'd0;
  assign i_widx   = in_i ? idx_reg : '0;
  assign i_done   = (state_reg == DONE) && !owner_d_reg;

  assign d_rvalid = in_d && !we_reg && mem_ready;
  assign d_wack   = in_d && we_reg && mem_ready;
  assign d_rdata  = d_rvalid ? mem_rdata : 32'd0;
  assign d_widx   = in_d ? idx_reg : '0;
  assign d_done   = (state_reg == DONE) && owner_d_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: burst-level reference model checked every cycle, directed scenarios
// with literal expectations, then a randomized traffic phase with occasional resets.
module tb_mem_arbiter;
  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_rvalid, i_done, d_rvalid, d_done, d_wack, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0]  i_widx, d_widx;
  logic [31:0] wb_base = 32'd0;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_store [logic [31:0]];

  mem_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_widx(i_widx), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_widx(d_widx), .d_done(d_done), .d_wack(d_wack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Writeback source: word value follows the index the arbiter is presenting.
  assign d_wdata = wb_base + 32'(d_widx);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: which client owns the port, how many words it has moved, pending done.
  int          m_owner = 0;   // 0 none, 1 I, 2 D
  int          m_words = 0;
  int          m_done  = 0;   // owner whose done strobe is due this cycle
  bit          m_last_d = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_base = 32'd0;

  task automatic model_reset();
    m_owner = 0; m_words = 0; m_done = 0; m_last_d = 1'b0; m_we = 1'b0; m_base = 32'd0;
  endtask

  task automatic model_step();
    int pick;
    if (m_owner != 0) begin
      if (mem_ready) begin
        m_words++;
        if (m_words == LW) begin
          $display("burst owner=%s base=%h we=%0d words=%0d", (m_owner == 1) ? "I" : "D",
                   m_base, m_we, LW);
          m_done  = m_owner;
          m_owner = 0;
          m_words = 0;
        end
      end
    end else if (m_done != 0) begin
      m_done = 0;
    end else begin
      pick = 0;
      if (i_req && d_req) pick = m_last_d ? 1 : 2;
      else if (i_req)     pick = 1;
      else if (d_req)     pick = 2;
      if (pick != 0) begin
        m_owner  = pick;
        m_words  = 0;
        m_last_d = (pick == 2);
        m_we     = (pick == 2) && d_we;
        m_base   = ((pick == 1) ? i_addr : d_addr) & ~32'(LW * 4 - 1);
      end
    end
  endtask

  task automatic check_outputs();
    logic        busy, own_i, own_d, rd, wr;
    logic [31:0] cur;
    if (!reset) begin
      check("reset_outputs", 32'(|{mem_req, mem_we, mem_addr, mem_wdata, i_rvalid, i_rdata,
            i_widx, i_done, d_rvalid, d_rdata, d_widx, d_done, d_wack}), 32'd0);
    end else begin
      busy  = (m_owner != 0);
      own_i = (m_owner == 1);
      own_d = (m_owner == 2);
      cur   = 32'(m_words);
      rd    = own_i || (own_d && !m_we);
      wr    = own_d && m_we;
      check("mem_req", 32'(mem_req), 32'(busy));
      check("mem_we", 32'(mem_we), 32'(busy && m_we));
      check("i_rvalid", 32'(i_rvalid), 32'(own_i && mem_ready));
      check("d_rvalid", 32'(d_rvalid), 32'(own_d && !m_we && mem_ready));
      check("d_wack", 32'(d_wack), 32'(wr && mem_ready));
      check("i_done", 32'(i_done), 32'(m_done == 1));
      check("d_done", 32'(d_done), 32'(m_done == 2));
      if (busy) check("mem_addr", mem_addr, m_base + cur * 4);
      if (own_i) check("i_widx", 32'(i_widx), cur);
      if (own_d) begin
        check("d_widx", 32'(d_widx), cur);
        check("mem_wdata", mem_wdata, wb_base + cur);
      end
      if (rd && mem_ready) check("rdata", own_i ? i_rdata : d_rdata, mem_rdata);
    end
  endtask

  // Compare process: outputs at the falling edge, model advance at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) model_reset();
      check_outputs();
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // Memory: fresh read data every cycle, records accepted writes.
  initial begin
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = $urandom;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && mem_we && mem_ready) mem_store[mem_addr] = mem_wdata;
    end
  end

  int got, seen, nd, ni, last_d, first_i, ddone, idone, stalls, fired;
  logic [31:0] a;

  initial begin
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0;
    step(); step();
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    step(); reset = 1'b1; step();

    // I refill, zero wait states
    i_addr = 32'h0000_1234; i_req = 1'b1; mem_ready = 1'b1;
    got = 0; seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (i_rvalid) begin
        check("i32_addr", mem_addr, 32'h1220 + 32'(got * 4));
        check("i32_widx", 32'(i_widx), 32'(got));
        got++;
      end
      if (i_done) begin
        check("i32_done_cycle", 32'(k), 32'd9);
        seen = 1;
      end
      step();
      if (k == 0) i_req = 1'b0;
    end
    check("i32_words", 32'(got), 32'd8);
    check("i32_done_seen", 32'(seen), 32'd1);

    // D writeback; inputs scrambled after grant to prove latching
    mem_store.delete();
    wb_base = 32'hA0; d_addr = 32'h40; d_we = 1'b1; d_req = 1'b1;
    got = 0; seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (d_wack) got++;
      if (d_done) seen = 1;
      step();
      if (k == 0) begin d_req = 1'b0; d_we = 1'b0; d_addr = 32'hFFFF_FFC0; end
    end
    check("wb_wacks", 32'(got), 32'd8);
    check("wb_done_seen", 32'(seen), 32'd1);
    for (int j = 0; j < 8; j++) begin
      a = 32'h40 + 32'(j * 4);
      check("wb_mem", mem_store.exists(a) ? mem_store[a] : 32'hDEAD_DEAD, 32'hA0 + 32'(j));
    end

    // Simultaneous requests right after reset: D first, then I
    reset = 1'b0; step();
    reset = 1'b1; i_addr = 32'h2000; d_addr = 32'h3000; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    nd = 0; ni = 0; last_d = -1; first_i = -1; ddone = -1; idone = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_rvalid) begin nd++; last_d = k; end
      if (i_rvalid) begin ni++; if (first_i < 0) first_i = k; end
      if (d_done) ddone = k;
      if (i_done) idone = k;
      step();
      if (ddone >= 0) d_req = 1'b0;
      if (idone >= 0) begin i_req = 1'b0; break; end
    end
    check("tie_d_done_cycle", 32'(ddone), 32'd9);
    check("tie_i_first_word", 32'(first_i), 32'(ddone + 2));
    check("tie_d_words", 32'(nd), 32'd8);
    check("tie_i_words", 32'(ni), 32'd8);
    check("tie_no_interleave", 32'(last_d < first_i), 32'd1);

    // Refill with three wait states on word 2
    i_addr = 32'h0000_8000; i_req = 1'b1; stalls = 0; got = 0; seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      @(negedge clk);
      if (i_rvalid) got++;
      if (i_done) begin check("stall_done_cycle", 32'(k), 32'd12); seen = 1; end
      step();
      if (k == 0) i_req = 1'b0;
      if (mem_req && i_widx == 3'd2 && stalls < 3) begin mem_ready = 1'b0; stalls++; end
      else mem_ready = 1'b1;
    end
    check("stall_words", 32'(got), 32'd8);
    check("stall_done_seen", 32'(seen), 32'd1);

    // Reset in the middle of an I burst with a D request pending
    i_addr = 32'h5000; i_req = 1'b1; fired = 0;
    for (int k = 0; k < 20 && fired == 0; k++) begin
      @(negedge clk);
      step();
      if (mem_req && i_widx == 3'd4) begin
        reset = 1'b0; i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000; fired = 1;
        @(negedge clk);
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'd0);
        step(); reset = 1'b1;
        @(negedge clk);
        check("rst_rel_idle", 32'(mem_req), 32'd0);
        step();
        @(negedge clk);
        check("post_rst_mem_req", 32'(mem_req), 32'd1);
        check("post_rst_d_widx", 32'(d_widx), 32'd0);
        check("post_rst_addr", mem_addr, 32'h6000);
      end
    end
    check("rst_fired", 32'(fired), 32'd1);
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      if (d_done) begin seen = 1; break; end
      step();
      @(negedge clk);
    end
    check("rst_d_done_seen", 32'(seen), 32'd1);
    step(); d_req = 1'b0;

    // Requester drops after two words; then stray ready pulses while idle
    i_addr = 32'h7000; i_req = 1'b1; got = 0; seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (i_rvalid) got++;
      if (i_done) seen = 1;
      step();
      if (got >= 2) i_req = 1'b0;
    end
    check("drop_words", 32'(got), 32'd8);
    check("drop_done_seen", 32'(seen), 32'd1);
    for (int j = 0; j < 3; j++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      check("idle_ready_strobes", 32'(|{i_rvalid, d_rvalid, d_wack, mem_req}), 32'd0);
      step();
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (i_req) begin if ($urandom_range(7) == 0) i_req = 1'b0; end
      else if ($urandom_range(3) == 0) i_req = 1'b1;
      if (d_req) begin if ($urandom_range(7) == 0) d_req = 1'b0; end
      else if ($urandom_range(3) == 0) d_req = 1'b1;
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_we      = ($urandom_range(1) != 0);
      wb_base   = $urandom;
      mem_ready = ($urandom_range(3) != 0);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(299) == 0) reset = 1'b0;
      step();
    end
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
